// File: rtl/steer_quad_encoder_if.sv
// Steering bus between the joystick mux and the quadrature encoder.
// master : drives clkdiv, mode, left, right, axis; observes steer, moving.
// slave  : the encoder side; consumes the requests, produces steer/moving.
interface steer_quad_encoder_if #(
    parameter int unsigned NCH   = 2,
    parameter int unsigned DIV_W = 16
);
    logic [DIV_W-1:0] clkdiv;
    logic [NCH-1:0]   mode;
    logic [NCH-1:0]   left;
    logic [NCH-1:0]   right;
    logic [8*NCH-1:0] axis;
    logic [2*NCH-1:0] steer;
    logic [NCH-1:0]   moving;

    modport master (output clkdiv, mode, left, right, axis, input steer, moving);
    modport slave  (input clkdiv, mode, left, right, axis, output steer, moving);
endinterface

// File: rtl/steer_quad_encoder.sv
// Multi-channel joystick/axis to Gray-coded quadrature steering converter.
// Ports:
//   CLK      : block clock (core pixel-rate clock)
//   Reset_n  : asynchronous active-low reset
//   bus      : slave side of steer_quad_encoder_if
//              clkdiv (shared base step period), mode/left/right/axis per channel in,
//              steer {A,B} per channel and moving per channel out.
module steer_quad_encoder #(
    parameter int unsigned NCH        = 2,
    parameter int unsigned DIV_W      = 16,
    parameter int unsigned RAMP_MAX   = 3,
    parameter int unsigned RAMP_STEPS = 8,
    parameter int unsigned DEADZONE   = 16,
    parameter int unsigned ACCEL_EN   = 1
) (
    input  logic                  CLK,
    input  logic                  Reset_n,
    steer_quad_encoder_if.slave   bus
);
    localparam int unsigned RL_W = 2;
    localparam int unsigned SC_W = $clog2(RAMP_STEPS + 1);

    localparam logic [1:0] DIR_Z = 2'b00;
    localparam logic [1:0] DIR_P = 2'b01;
    localparam logic [1:0] DIR_N = 2'b11;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    // Next Gray phase: forward 00->01->11->10->00, reverse the opposite way.
    function automatic logic [1:0] step_ph(input logic [1:0] ph, input logic fwd);
        logic [1:0] nx;
        case (ph)
            2'b00:   nx = fwd ? 2'b01 : 2'b10;
            2'b01:   nx = fwd ? 2'b11 : 2'b00;
            2'b11:   nx = fwd ? 2'b10 : 2'b01;
            default: nx = fwd ? 2'b00 : 2'b11;
        endcase
        return nx;
    endfunction

    // Shifted period, never below one cycle.
    function automatic logic [DIV_W-1:0] period_f(input logic [DIV_W-1:0] b, input logic [1:0] sh);
        logic [DIV_W-1:0] v;
        v = b >> sh;
        return (v == '0) ? DIV_W'(1) : v;
    endfunction

    logic [DIV_W-1:0] base_c;
    assign base_c = (bus.clkdiv == '0) ? DIV_W'(1) : bus.clkdiv;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic signed [7:0] ax_c;
        logic [1:0]        dir_c;
        logic [1:0]        ash_c;

        logic [1:0]        dir_q;
        logic              mode_q;
        logic [1:0]        ash_q;
        logic              moving_q;

        state_t            state_q;
        logic [DIV_W-1:0]  cnt_q;
        logic [1:0]        phase_q;
        logic [RL_W-1:0]   ramp_q;
        logic [SC_W-1:0]   sc_q;
        logic [1:0]        cur_dir_q;
        logic              cur_mode_q;

        logic              wrap_c;
        logic [RL_W-1:0]   ramp_nx_c;
        logic [DIV_W-1:0]  p_step_c;
        logic [DIV_W-1:0]  p_zero_c;

        // Decode direction and analog rate shift (|axis| bits [6:5], -128 saturated).
        always_comb begin
            ax_c  = bus.axis[8*i +: 8];
            dir_c = DIR_Z;
            ash_c = (ax_c == 8'sh80) ? 2'b11 :
                    ax_c[7]          ? 2'((8'(-ax_c)) >> 5) : ax_c[6:5];
            if (bus.mode[i]) begin
                if (int'(ax_c) > int'(DEADZONE))       dir_c = DIR_P;
                else if (int'(ax_c) < -int'(DEADZONE)) dir_c = DIR_N;
            end else if (bus.right[i] && !bus.left[i]) begin
                dir_c = DIR_P;
            end else if (bus.left[i] && !bus.right[i]) begin
                dir_c = DIR_N;
            end
        end

        // Input stage: one cycle of latency for every decision.
        always_ff @(posedge CLK or negedge Reset_n) begin
            if (!Reset_n) begin
                dir_q    <= DIR_Z;
                mode_q   <= 1'b0;
                ash_q    <= 2'b00;
                moving_q <= 1'b0;
            end else begin
                dir_q    <= dir_c;
                mode_q   <= bus.mode[i];
                ash_q    <= ash_c;
                moving_q <= (dir_c != DIR_Z);
            end
        end

        // Ramp level that applies after the current step (reload uses the new level).
        always_comb begin
            wrap_c    = (sc_q == SC_W'(RAMP_STEPS - 1));
            ramp_nx_c = ramp_q;
            if ((ACCEL_EN != 0) && !mode_q && wrap_c && (ramp_q < RL_W'(RAMP_MAX)))
                ramp_nx_c = ramp_q + RL_W'(1);
            p_step_c = period_f(base_c, mode_q ? ash_q : ramp_nx_c);
            p_zero_c = period_f(base_c, mode_q ? ash_q : 2'b00);
        end

        // Rate FSM. The input-register cycle counts as the first period cycle,
        // so leaving IDLE loads P-2 (or steps at once when P is 1).
        always_ff @(posedge CLK or negedge Reset_n) begin
            if (!Reset_n) begin
                state_q    <= S_IDLE;
                cnt_q      <= '0;
                phase_q    <= 2'b00;
                ramp_q     <= '0;
                sc_q       <= '0;
                cur_dir_q  <= DIR_Z;
                cur_mode_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        cnt_q  <= '0;
                        ramp_q <= '0;
                        sc_q   <= '0;
                        if (dir_q != DIR_Z) begin
                            state_q    <= S_RUN;
                            cur_dir_q  <= dir_q;
                            cur_mode_q <= mode_q;
                            if (p_zero_c == DIV_W'(1))
                                phase_q <= step_ph(phase_q, dir_q == DIR_P);
                            else
                                cnt_q <= p_zero_c - DIV_W'(2);
                        end
                    end
                    default: begin
                        if (dir_q == DIR_Z) begin
                            state_q <= S_IDLE;
                            cnt_q   <= '0;
                            ramp_q  <= '0;
                            sc_q    <= '0;
                        end else if ((dir_q != cur_dir_q) || (mode_q != cur_mode_q)) begin
                            // Reversal or mode change: restart the period, no step.
                            cur_dir_q  <= dir_q;
                            cur_mode_q <= mode_q;
                            cnt_q      <= p_zero_c - DIV_W'(1);
                            ramp_q     <= '0;
                            sc_q       <= '0;
                        end else if (cnt_q != '0) begin
                            cnt_q <= cnt_q - DIV_W'(1);
                        end else begin
                            phase_q <= step_ph(phase_q, dir_q == DIR_P);
                            cnt_q   <= p_step_c - DIV_W'(1);
                            if ((ACCEL_EN != 0) && !mode_q) begin
                                if (wrap_c) begin
                                    sc_q   <= '0;
                                    ramp_q <= ramp_nx_c;
                                end else begin
                                    sc_q <= sc_q + SC_W'(1);
                                end
                            end
                        end
                    end
                endcase
            end
        end

        assign bus.steer[2*i +: 2] = phase_q;
        assign bus.moving[i]       = moving_q;
    end
endmodule

// File: tb/tb_steer_quad_encoder.sv
// Directed bench for steer_quad_encoder: one accelerating instance (bus_a)
// and one fixed-period instance (bus_n) driven with identical inputs.
module tb_steer_quad_encoder;
    logic CLK = 1'b0;
    logic Reset_n = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   n;

    always #5 CLK = ~CLK;

    steer_quad_encoder_if #(.NCH(2), .DIV_W(16)) bus_a ();
    steer_quad_encoder_if #(.NCH(2), .DIV_W(16)) bus_n ();

    assign bus_n.clkdiv = bus_a.clkdiv;
    assign bus_n.mode   = bus_a.mode;
    assign bus_n.left   = bus_a.left;
    assign bus_n.right  = bus_a.right;
    assign bus_n.axis   = bus_a.axis;

    steer_quad_encoder #(.ACCEL_EN(1)) dut_a (.CLK(CLK), .Reset_n(Reset_n), .bus(bus_a));
    steer_quad_encoder #(.ACCEL_EN(0)) dut_n (.CLK(CLK), .Reset_n(Reset_n), .bus(bus_n));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) @(posedge CLK);
        #1;
    endtask

    // Edges until bus_a channel ch changes phase, bounded at 100.
    task automatic wait_change(input int ch, output int cnt);
        logic [3:0] s;
        logic [1:0] p0;
        s   = bus_a.steer;
        p0  = s[2*ch +: 2];
        cnt = 0;
        do begin
            tick(1);
            cnt++;
            s = bus_a.steer;
        end while ((s[2*ch +: 2] == p0) && (cnt < 100));
    endtask

    initial begin
        bus_a.clkdiv = 16'd4;
        bus_a.mode   = 2'b00;
        bus_a.left   = 2'b00;
        bus_a.right  = 2'b00;
        bus_a.axis   = 16'h0000;
        #2 Reset_n = 1'b0;
        tick(3);
        Reset_n = 1'b1;
        chk("rst_steer", 32'(bus_a.steer), 32'h0);
        chk("rst_moving", 32'(bus_a.moving), 32'h0);
        tick(2);

        // Digital forward, P=4 on the fixed-period instance.
        bus_a.right = 2'b01;
        chk("fwd_moving_pre", 32'(bus_n.moving[0]), 32'h0);
        for (int k = 1; k <= 17; k++) begin
            tick(1);
            if (k == 1)  chk("fwd_moving_e1", 32'(bus_n.moving[0]), 32'h1);
            if (k == 4)  chk("fwd_e4", 32'(bus_n.steer[1:0]), 32'h0);
            if (k == 5)  chk("fwd_e5", 32'(bus_n.steer[1:0]), 32'h1);
            if (k == 9)  chk("fwd_e9", 32'(bus_n.steer[1:0]), 32'h3);
            if (k == 13) chk("fwd_e13", 32'(bus_n.steer[1:0]), 32'h2);
            if (k == 17) chk("fwd_e17", 32'(bus_n.steer[1:0]), 32'h0);
        end
        tick(8);
        chk("fwd_e25", 32'(bus_n.steer[1:0]), 32'h3);

        // Reversal timed so the reversal cycle coincides with an expiring count.
        tick(2);
        bus_a.right = 2'b00;
        bus_a.left  = 2'b01;
        tick(2);
        chk("rev_no_step", 32'(bus_n.steer[1:0]), 32'h3);
        tick(3);
        chk("rev_r5", 32'(bus_n.steer[1:0]), 32'h3);
        tick(1);
        chk("rev_r6", 32'(bus_n.steer[1:0]), 32'h1);
        tick(4);
        chk("rev_r10", 32'(bus_n.steer[1:0]), 32'h0);

        // Both buttons: idle, phase held.
        bus_a.right = 2'b01;
        tick(1);
        chk("conf_moving", 32'(bus_n.moving[0]), 32'h0);
        tick(5);
        chk("conf_hold", 32'(bus_n.steer[1:0]), 32'h0);
        bus_a.left  = 2'b00;
        bus_a.right = 2'b00;
        tick(3);

        // Hold acceleration, base 16.
        bus_a.clkdiv = 16'd16;
        bus_a.right  = 2'b01;
        wait_change(0, n);
        chk("acc_first", 32'(n), 32'd17);
        for (int s = 2; s <= 27; s++) begin
            wait_change(0, n);
            chk($sformatf("acc_step%0d", s), 32'(n),
                (s <= 8) ? 32'd16 : (s <= 16) ? 32'd8 : (s <= 24) ? 32'd4 : 32'd2);
        end
        chk("acc_phase", 32'(bus_a.steer[1:0]), 32'h2);
        chk("noacc_phase", 32'(bus_n.steer[1:0]), 32'h3);
        chk("ch1_untouched", 32'(bus_a.steer[3:2]), 32'h0);
        chk("ch1_idle", 32'(bus_a.moving[1]), 32'h0);

        bus_a.right = 2'b00;
        tick(3);
        bus_a.right = 2'b01;
        wait_change(0, n);
        chk("acc_release", 32'(n), 32'd17);
        chk("acc_release_ph", 32'(bus_a.steer[1:0]), 32'h0);
        bus_a.right = 2'b00;
        tick(3);

        // Analog channel 1, base 64.
        bus_a.clkdiv = 16'd64;
        bus_a.mode   = 2'b10;
        bus_a.axis   = {8'd100, 8'd0};
        wait_change(1, n);
        chk("an100_first", 32'(n), 32'd9);
        chk("an100_ph1", 32'(bus_a.steer[3:2]), 32'h1);
        wait_change(1, n);
        chk("an100_per", 32'(n), 32'd8);
        chk("an100_ph2", 32'(bus_a.steer[3:2]), 32'h3);
        bus_a.axis = {8'hD8, 8'd0};
        wait_change(1, n);
        chk("an_m40_first", 32'(n), 32'd34);
        chk("an_m40_ph1", 32'(bus_a.steer[3:2]), 32'h1);
        wait_change(1, n);
        chk("an_m40_per", 32'(n), 32'd32);
        chk("an_m40_ph2", 32'(bus_a.steer[3:2]), 32'h0);
        bus_a.axis = {8'd10, 8'd0};
        tick(1);
        chk("an_dead_moving", 32'(bus_a.moving[1]), 32'h0);
        tick(20);
        chk("an_dead_hold", 32'(bus_a.steer[3:2]), 32'h0);
        bus_a.axis = {8'h80, 8'd0};
        wait_change(1, n);
        chk("an_m128_first", 32'(n), 32'd9);
        chk("an_m128_ph1", 32'(bus_a.steer[3:2]), 32'h2);
        wait_change(1, n);
        chk("an_m128_per", 32'(n), 32'd8);
        chk("an_m128_ph2", 32'(bus_a.steer[3:2]), 32'h3);
        bus_a.axis = 16'h0000;
        bus_a.mode = 2'b00;
        tick(3);

        // clkdiv=0 steps every cycle.
        bus_a.clkdiv = 16'd0;
        bus_a.right  = 2'b01;
        wait_change(0, n);
        chk("div0_first", 32'(n), 32'd2);
        for (int s = 2; s <= 4; s++) begin
            wait_change(0, n);
            chk($sformatf("div0_step%0d", s), 32'(n), 32'd1);
        end
        chk("div0_phase", 32'(bus_a.steer[1:0]), 32'h0);

        // New clkdiv applies only at the next reload.
        bus_a.clkdiv = 16'd4;
        wait_change(0, n);
        chk("div_chg_next", 32'(n), 32'd1);
        wait_change(0, n);
        chk("div_chg_reload", 32'(n), 32'd4);
        chk("div_chg_phase", 32'(bus_a.steer[1:0]), 32'h3);
        chk("ch1_hold", 32'(bus_a.steer[3:2]), 32'h3);

        // Asynchronous reset mid-run.
        #3 Reset_n = 1'b0;
        #1;
        chk("arst_steer_a", 32'(bus_a.steer), 32'h0);
        chk("arst_moving_a", 32'(bus_a.moving), 32'h0);
        chk("arst_steer_n", 32'(bus_n.steer), 32'h0);
        tick(2);
        Reset_n = 1'b1;
        wait_change(0, n);
        chk("arst_first", 32'(n), 32'd5);
        chk("arst_phase", 32'(bus_a.steer[1:0]), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
